// File: rtl/rssi_window_avg_if.sv
// rssi_window_avg_if: sample stream in, averaged RSSI triple out, with drop counter
interface rssi_window_avg_if #(
  parameter int RSSI_W = 20
);
  logic                     in_valid;
  logic [1:0]               in_id;
  logic signed [RSSI_W-1:0] in_rssi;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [RSSI_W-1:0] rssiA;
  logic signed [RSSI_W-1:0] rssiB;
  logic signed [RSSI_W-1:0] rssiC;
  logic [7:0]               drop_cnt;
  modport slave (
    input  in_valid, in_id, in_rssi, out_ready,
    output in_ready, out_valid, rssiA, rssiB, rssiC, drop_cnt
  );
  modport master (
    output in_valid, in_id, in_rssi, out_ready,
    input  in_ready, out_valid, rssiA, rssiB, rssiC, drop_cnt
  );
endinterface

// File: rtl/rssi_window_avg.sv
// rssi_window_avg: per-anchor windowed RSSI averaging with rounded output and valid/ready handoff
module rssi_window_avg #(
  parameter int RSSI_W = 20,
  parameter int LOG2N  = 3
) (
  input logic             clk,
  input logic             rst_n,
  rssi_window_avg_if.slave ifc
);
  localparam int AW = RSSI_W + LOG2N;
  localparam int CW = LOG2N + 1;
  localparam logic [CW-1:0] FULL = CW'(2 ** LOG2N);
  localparam logic signed [AW-1:0] HALF = AW'(2 ** (LOG2N - 1));
  typedef enum logic [1:0] {ACCUM, AVG, HOLD} state_t;
  state_t state_q, state_d;
  logic signed [AW-1:0] acc_q [3];
  logic signed [AW-1:0] acc_d [3];
  logic signed [AW-1:0] rnd [3];
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic signed [RSSI_W-1:0] rssi_q [3];
  logic signed [RSSI_W-1:0] rssi_d [3];
  logic [7:0] drop_q, drop_d;
  logic taken;
  logic all_full;
  assign all_full = (cnt_q[0] == FULL) && (cnt_q[1] == FULL) && (cnt_q[2] == FULL);
  assign ifc.in_ready  = (state_q == ACCUM);
  assign ifc.out_valid = (state_q == HOLD);
  assign ifc.rssiA     = rssi_q[0];
  assign ifc.rssiB     = rssi_q[1];
  assign ifc.rssiC     = rssi_q[2];
  assign ifc.drop_cnt  = drop_q;
  // next state: accumulate or drop samples, round-average once, then hold until taken
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rssi_d  = rssi_q;
    drop_d  = drop_q;
    taken   = 1'b0;
    for (int i = 0; i < 3; i++) rnd[i] = acc_q[i] + HALF;
    case (state_q)
      ACCUM: begin
        if (ifc.in_valid) begin
          for (int i = 0; i < 3; i++)
            if (ifc.in_id == 2'(i) && cnt_q[i] != FULL) begin
              acc_d[i] = acc_q[i] + AW'(ifc.in_rssi);
              cnt_d[i] = cnt_q[i] + CW'(1);
              taken    = 1'b1;
            end
          drop_d = (taken || drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
        end
        state_d = all_full ? AVG : ACCUM;
      end
      AVG: begin
        for (int i = 0; i < 3; i++) rssi_d[i] = RSSI_W'(rnd[i] >>> LOG2N);
        state_d = HOLD;
      end
      HOLD: begin
        if (ifc.out_ready) begin
          state_d = ACCUM;
          acc_d   = '{default: '0};
          cnt_d   = '{default: '0};
        end
      end
      default: state_d = ACCUM;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '{default: '0};
      cnt_q   <= '{default: '0};
      rssi_q  <= '{default: '0};
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rssi_q  <= rssi_d;
      drop_q  <= drop_d;
    end
  end
endmodule

// File: tb/tb_rssi_window_avg.sv
// tb_rssi_window_avg: randomized and directed windows checked against an arithmetic averaging model
module tb_rssi_window_avg;
  localparam int W = 20;
  localparam int L = 3;
  localparam int N = 1 << L;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  longint sum_m [3];
  int n_m [3];
  int drop_m = 0;
  rssi_window_avg_if #(.RSSI_W(W)) ifc ();
  rssi_window_avg #(.RSSI_W(W), .LOG2N(L)) dut (.clk(clk), .rst_n(rst_n), .ifc(ifc));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic signed [31:0] avg(input longint s);
    longint q = s + N / 2;
    return (q >= 0) ? 32'(q / N) : 32'(-((-q + N - 1) / N));
  endfunction
  function automatic bit all_full();
    return n_m[0] == N && n_m[1] == N && n_m[2] == N;
  endfunction
  task automatic m_clear();
    for (int i = 0; i < 3; i++) begin
      sum_m[i] = 0;
      n_m[i] = 0;
    end
  endtask
  task automatic send(input int id, input longint val);
    chk("in_ready_accum", ifc.in_ready, 1);
    chk("drop_cnt", ifc.drop_cnt, drop_m);
    ifc.in_valid = 1'b1;
    ifc.in_id = 2'(id);
    ifc.in_rssi = W'(val);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    if (id < 3 && n_m[id] < N) begin
      sum_m[id] += val;
      n_m[id]++;
    end else if (drop_m < 255) drop_m++;
  endtask
  task automatic idle();
    chk("in_ready_idle", ifc.in_ready, 1);
    chk("out_valid_idle", ifc.out_valid, 0);
    ifc.out_ready = 1'($urandom);
    @(negedge clk);
    ifc.out_ready = 1'b0;
  endtask
  task automatic finish_window(input int hold);
    logic signed [31:0] ea, eb, ec;
    ea = avg(sum_m[0]);
    eb = avg(sum_m[1]);
    ec = avg(sum_m[2]);
    chk("in_ready_full", ifc.in_ready, 1);
    chk("out_valid_full", ifc.out_valid, 0);
    ifc.out_ready = 1'($urandom);
    @(negedge clk);
    chk("in_ready_avg", ifc.in_ready, 0);
    chk("out_valid_avg", ifc.out_valid, 0);
    ifc.out_ready = 1'($urandom);
    @(negedge clk);
    ifc.out_ready = 1'b0;
    chk("out_valid_hold", ifc.out_valid, 1);
    chk("rssiA", ifc.rssiA, ea);
    chk("rssiB", ifc.rssiB, eb);
    chk("rssiC", ifc.rssiC, ec);
    chk("drop_hold", ifc.drop_cnt, drop_m);
    for (int k = 0; k < hold; k++) begin
      ifc.in_valid = 1'b1;
      ifc.in_id = 2'($urandom_range(0, 3));
      ifc.in_rssi = W'($urandom);
      @(negedge clk);
      chk("in_ready_bp", ifc.in_ready, 0);
      chk("out_valid_bp", ifc.out_valid, 1);
      chk("rssiA_bp", ifc.rssiA, ea);
      chk("rssiB_bp", ifc.rssiB, eb);
      chk("rssiC_bp", ifc.rssiC, ec);
      chk("drop_bp", ifc.drop_cnt, drop_m);
    end
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    @(negedge clk);
    ifc.out_ready = 1'b0;
    chk("out_valid_done", ifc.out_valid, 0);
    chk("in_ready_done", ifc.in_ready, 1);
    chk("rssiA_kept", ifc.rssiA, ea);
    m_clear();
  endtask
  task automatic random_window(input int hold);
    logic signed [W-1:0] v;
    int guard = 0;
    while (!all_full() && guard < 2000) begin
      guard++;
      v = W'($urandom);
      if ($urandom_range(0, 3) == 0) idle();
      else send($urandom_range(0, 3), v);
    end
    chk("window_fill_bound", 32'(all_full()), 1);
    finish_window(hold);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, ifc.in_ready, 1);
    chk({tag, "_out_valid"}, ifc.out_valid, 0);
    chk({tag, "_rssiA"}, ifc.rssiA, 0);
    chk({tag, "_rssiB"}, ifc.rssiB, 0);
    chk({tag, "_rssiC"}, ifc.rssiC, 0);
    chk({tag, "_drop"}, ifc.drop_cnt, 0);
  endtask
  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_id = 2'd0;
    ifc.in_rssi = '0;
    ifc.out_ready = 1'b0;
    m_clear();
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      send(0, -1000);
      send(1, -2000);
      send(2, -3000);
    end
    finish_window(3);
    for (int i = 0; i < N - 1; i++) begin
      send(0, -100);
      send(1, -100);
      send(2, 0);
    end
    send(0, -104);
    send(1, -105);
    send(2, 0);
    finish_window(2);
    for (int i = 0; i < N + 2; i++) send(0, 100 * (i + 1));
    send(3, 777);
    for (int i = 0; i < N; i++) begin
      send(1, 50 - i);
      send(2, -7 * i);
    end
    chk("drop_overfill", ifc.drop_cnt, 3);
    finish_window(20);
    for (int w = 0; w < 6; w++) random_window($urandom_range(0, 5));
    for (int i = 0; i < N + 300; i++) send(0, -(i + 1));
    for (int i = 0; i < N; i++) begin
      send(1, 3 * i);
      send(2, 524287 - i);
    end
    chk("drop_saturated", ifc.drop_cnt, 255);
    finish_window(1);
    random_window(2);
    for (int i = 0; i < 5; i++) send(0, 12345);
    #2 rst_n = 1'b0;
    #1;
    m_clear();
    drop_m = 0;
    check_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    check_zero("post_reset");
    random_window(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
